// File: rtl/led_share_arb.sv
// Round-robin owner arbitration for a shared LED bank, with minimum hold time,
// ownership timeout and registered LED drive.
module led_share_arb #(
  parameter int unsigned   W           = 12,
  parameter int unsigned   HOLD_CYC    = 25_000_000,
  parameter int unsigned   TIMEOUT_CYC = 250_000_000,
  parameter logic [W-1:0]  IDLE_PAT    = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   req,
  input  logic [W-1:0] data0,
  input  logic [W-1:0] data1,
  input  logic [W-1:0] data2,
  output logic [2:0]   grant,
  output logic [1:0]   owner,
  output logic [W-1:0] led,
  output logic         revoked
);

  localparam int unsigned CW        = 32;
  localparam logic [CW-1:0] HOLD_LAST = 32'(HOLD_CYC - 1);
  localparam logic [CW-1:0] TMO_LAST  = 32'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] TMO_SAT   = 32'(TIMEOUT_CYC);
  localparam logic [1:0]    NO_OWNER  = 2'd3;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_OWN  = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [2:0]    grant_q, grant_d;
  logic [1:0]    owner_q, owner_d;
  logic [W-1:0]  led_q, led_d;
  logic          revoked_q, revoked_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    last_q, last_d;

  logic          pick_vld_c;
  logic [1:0]    pick_idx_c;
  logic [1:0]    cand_c;
  logic [W-1:0]  own_data_c;
  logic          own_req_c;
  logic          others_req_c;
  logic          release_c;
  logic          timeout_c;

  // Round-robin search starting just after the previous owner.
  always_comb begin
    pick_vld_c = 1'b0;
    pick_idx_c = 2'd0;
    cand_c     = last_q;
    for (int k = 0; k < 3; k++) begin
      cand_c = (cand_c >= 2'd2) ? 2'd0 : cand_c + 2'd1;
      if (!pick_vld_c && req[cand_c]) begin
        pick_vld_c = 1'b1;
        pick_idx_c = cand_c;
      end
    end
  end

  always_comb begin
    case (owner_q)
      2'd0:    own_data_c = data0;
      2'd1:    own_data_c = data1;
      2'd2:    own_data_c = data2;
      default: own_data_c = IDLE_PAT;
    endcase
  end

  assign own_req_c    = |(req & grant_q);
  assign others_req_c = |(req & ~grant_q);
  assign release_c    = !own_req_c && (cnt_q >= HOLD_LAST);
  assign timeout_c    = others_req_c && (cnt_q >= TMO_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      grant_q   <= 3'b000;
      owner_q   <= NO_OWNER;
      led_q     <= IDLE_PAT;
      revoked_q <= 1'b0;
      cnt_q     <= '0;
      last_q    <= 2'd2;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      led_q     <= led_d;
      revoked_q <= revoked_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
    end
  end

  // Release wins over timeout, so revoked only pulses when the owner still wants the LEDs.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    led_d     = led_q;
    revoked_d = 1'b0;
    cnt_d     = cnt_q;
    last_d    = last_q;
    case (state_q)
      S_IDLE: begin
        grant_d = 3'b000;
        owner_d = NO_OWNER;
        led_d   = IDLE_PAT;
        if (pick_vld_c) begin
          state_d = S_OWN;
          grant_d = 3'b001 << pick_idx_c;
          owner_d = pick_idx_c;
          last_d  = pick_idx_c;
          cnt_d   = '0;
        end
      end
      S_OWN: begin
        cnt_d = (cnt_q >= TMO_SAT) ? cnt_q : cnt_q + 32'd1;
        if (own_req_c) begin
          led_d = own_data_c;
        end
        if (release_c || timeout_c) begin
          state_d   = S_IDLE;
          grant_d   = 3'b000;
          owner_d   = NO_OWNER;
          led_d     = IDLE_PAT;
          cnt_d     = '0;
          revoked_d = !release_c;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign grant   = grant_q;
  assign owner   = owner_q;
  assign led     = led_q;
  assign revoked = revoked_q;

endmodule

// File: tb/tb_led_share_arb.sv
// Bench for led_share_arb: table-driven vectors plus hand sequences for hold,
// timeout and reset corners; expectations go through a scoreboard queue.
module tb_led_share_arb;

  typedef struct packed {
    logic [2:0]  g;
    logic [1:0]  o;
    logic [11:0] l;
    logic        r;
  } exp_t;

  typedef struct {
    logic        rst_n;
    logic [2:0]  req;
    logic [11:0] d0;
    logic [11:0] d1;
    logic [11:0] d2;
    exp_t        e;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [2:0]  req;
  logic [11:0] data0, data1, data2;
  logic [2:0]  grant;
  logic [1:0]  owner;
  logic [11:0] led;
  logic        revoked;

  int n_chk  = 0;
  int n_pass = 0;

  exp_t  sb[$];
  string sb_nm[$];

  led_share_arb #(
    .W(12), .HOLD_CYC(4), .TIMEOUT_CYC(16), .IDLE_PAT(12'h000)
  ) dut (
    .clk(clk), .rst(rst), .req(req),
    .data0(data0), .data1(data1), .data2(data2),
    .grant(grant), .owner(owner), .led(led), .revoked(revoked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk_e(input logic [2:0] g, input logic [1:0] o,
                                input logic [11:0] l, input logic r);
    exp_t e;
    e.g = g; e.o = o; e.l = l; e.r = r;
    return e;
  endfunction

  function automatic vec_t mk_v(input logic rn, input logic [2:0] rq,
                                input logic [11:0] a, input logic [11:0] b,
                                input logic [11:0] c, input exp_t e);
    vec_t v;
    v.rst_n = rn; v.req = rq; v.d0 = a; v.d1 = b; v.d2 = c; v.e = e;
    return v;
  endfunction

  // Drive one cycle of inputs, queue the expected post-edge outputs, then compare.
  task automatic step(input logic rn, input logic [2:0] rq, input logic [11:0] a,
                      input logic [11:0] b, input logic [11:0] c,
                      input exp_t e, input string nm);
    exp_t  want;
    exp_t  got;
    string wnm;
    @(negedge clk);
    rst = rn; req = rq; data0 = a; data1 = b; data2 = c;
    sb.push_back(e);
    sb_nm.push_back(nm);
    @(posedge clk);
    #1;
    want = sb.pop_front();
    wnm  = sb_nm.pop_front();
    got  = mk_e(grant, owner, led, revoked);
    n_chk++;
    if (got !== want)
      $display("FAIL %s: got grant=%b owner=%0d led=%h revoked=%b, want grant=%b owner=%0d led=%h revoked=%b",
               wnm, got.g, got.o, got.l, got.r, want.g, want.o, want.l, want.r);
    else
      n_pass++;
  endtask

  vec_t        tbl[17];
  exp_t        idle_e;
  logic [11:0] dat[3];
  logic [2:0]  oh;
  int          ord[4];

  initial begin
    rst = 1'b0; req = 3'b000; data0 = '0; data1 = '0; data2 = '0;
    idle_e = mk_e(3'b000, 2'd3, 12'h000, 1'b0);

    // Single request after reset, then reset mid-grant and pointer restart.
    tbl[0]  = mk_v(1'b0, 3'b000, 12'h801, 12'h000, 12'h000, idle_e);
    tbl[1]  = mk_v(1'b0, 3'b000, 12'h801, 12'h000, 12'h000, idle_e);
    tbl[2]  = mk_v(1'b1, 3'b001, 12'h801, 12'h000, 12'h000, mk_e(3'b001, 2'd0, 12'h000, 1'b0));
    tbl[3]  = mk_v(1'b1, 3'b001, 12'h801, 12'h000, 12'h000, mk_e(3'b001, 2'd0, 12'h801, 1'b0));
    tbl[4]  = mk_v(1'b1, 3'b001, 12'h801, 12'h000, 12'h000, mk_e(3'b001, 2'd0, 12'h801, 1'b0));
    tbl[5]  = mk_v(1'b1, 3'b001, 12'h801, 12'h000, 12'h000, mk_e(3'b001, 2'd0, 12'h801, 1'b0));
    tbl[6]  = mk_v(1'b1, 3'b001, 12'h801, 12'h000, 12'h000, mk_e(3'b001, 2'd0, 12'h801, 1'b0));
    tbl[7]  = mk_v(1'b1, 3'b001, 12'h801, 12'h000, 12'h000, mk_e(3'b001, 2'd0, 12'h801, 1'b0));
    tbl[8]  = mk_v(1'b1, 3'b000, 12'h801, 12'h000, 12'h000, idle_e);
    tbl[9]  = mk_v(1'b1, 3'b000, 12'h801, 12'h000, 12'h000, idle_e);
    tbl[10] = mk_v(1'b0, 3'b000, 12'h000, 12'h000, 12'h3c3, idle_e);
    tbl[11] = mk_v(1'b1, 3'b100, 12'h000, 12'h000, 12'h3c3, mk_e(3'b100, 2'd2, 12'h000, 1'b0));
    tbl[12] = mk_v(1'b1, 3'b100, 12'h000, 12'h000, 12'h3c3, mk_e(3'b100, 2'd2, 12'h3c3, 1'b0));
    tbl[13] = mk_v(1'b0, 3'b100, 12'h000, 12'h000, 12'h3c3, idle_e);
    tbl[14] = mk_v(1'b1, 3'b101, 12'h0a5, 12'h000, 12'h3c3, mk_e(3'b001, 2'd0, 12'h000, 1'b0));
    tbl[15] = mk_v(1'b1, 3'b101, 12'h0a5, 12'h000, 12'h3c3, mk_e(3'b001, 2'd0, 12'h0a5, 1'b0));
    tbl[16] = mk_v(1'b1, 3'b100, 12'h0a5, 12'h000, 12'h3c3, mk_e(3'b001, 2'd0, 12'h0a5, 1'b0));

    for (int i = 0; i < 17; i++)
      step(tbl[i].rst_n, tbl[i].req, tbl[i].d0, tbl[i].d1, tbl[i].d2, tbl[i].e,
           $sformatf("tbl[%0d]", i));

    // Round robin with all three requesting; one idle cycle between owners.
    dat[0] = 12'h111; dat[1] = 12'h222; dat[2] = 12'h444;
    ord[0] = 0; ord[1] = 1; ord[2] = 2; ord[3] = 0;
    step(1'b0, 3'b000, dat[0], dat[1], dat[2], idle_e, "rr_rst");
    for (int g = 0; g < 4; g++) begin
      oh = 3'b001 << ord[g];
      step(1'b1, 3'b111, dat[0], dat[1], dat[2], mk_e(oh, 2'(ord[g]), 12'h000, 1'b0), "rr_grant");
      for (int k = 1; k <= 4; k++)
        step(1'b1, 3'b111, dat[0], dat[1], dat[2], mk_e(oh, 2'(ord[g]), dat[ord[g]], 1'b0), "rr_own");
      step(1'b1, 3'b111 & ~oh, dat[0], dat[1], dat[2], idle_e, "rr_gap");
    end

    // Early drop: LED frozen, grant held to the end of the minimum hold.
    step(1'b0, 3'b000, 12'h000, 12'hfff, 12'h000, idle_e, "ed_rst");
    step(1'b1, 3'b010, 12'h000, 12'hfff, 12'h000, mk_e(3'b010, 2'd1, 12'h000, 1'b0), "ed_grant");
    step(1'b1, 3'b010, 12'h000, 12'hfff, 12'h000, mk_e(3'b010, 2'd1, 12'hfff, 1'b0), "ed_led");
    step(1'b1, 3'b000, 12'h000, 12'h0f0, 12'h000, mk_e(3'b010, 2'd1, 12'hfff, 1'b0), "ed_freeze1");
    step(1'b1, 3'b000, 12'h000, 12'h0f0, 12'h000, mk_e(3'b010, 2'd1, 12'hfff, 1'b0), "ed_freeze2");
    step(1'b1, 3'b000, 12'h000, 12'h0f0, 12'h000, idle_e, "ed_rel");

    // Re-raising req during the hold window resumes sampling without re-grant.
    step(1'b0, 3'b000, 12'h00f, 12'h000, 12'h000, idle_e, "rr2_rst");
    step(1'b1, 3'b001, 12'h00f, 12'h000, 12'h000, mk_e(3'b001, 2'd0, 12'h000, 1'b0), "rs_grant");
    step(1'b1, 3'b000, 12'h00f, 12'h000, 12'h000, mk_e(3'b001, 2'd0, 12'h000, 1'b0), "rs_drop");
    step(1'b1, 3'b001, 12'h00f, 12'h000, 12'h000, mk_e(3'b001, 2'd0, 12'h00f, 1'b0), "rs_resume");
    step(1'b1, 3'b001, 12'h00e, 12'h000, 12'h000, mk_e(3'b001, 2'd0, 12'h00e, 1'b0), "rs_track");
    step(1'b1, 3'b000, 12'h00e, 12'h000, 12'h000, idle_e, "rs_rel");

    // Timeout revocation with source 2 waiting, then source 0 re-queued behind it.
    step(1'b0, 3'b000, 12'h5a5, 12'h000, 12'h3c3, idle_e, "to_rst");
    step(1'b1, 3'b001, 12'h5a5, 12'h000, 12'h3c3, mk_e(3'b001, 2'd0, 12'h000, 1'b0), "to_grant");
    for (int n = 2; n <= 16; n++)
      step(1'b1, (n >= 7) ? 3'b101 : 3'b001, 12'h5a5, 12'h000, 12'h3c3,
           mk_e(3'b001, 2'd0, 12'h5a5, 1'b0), "to_own");
    step(1'b1, 3'b101, 12'h5a5, 12'h000, 12'h3c3, mk_e(3'b000, 2'd3, 12'h000, 1'b1), "to_revoke");
    step(1'b1, 3'b101, 12'h5a5, 12'h000, 12'h3c3, mk_e(3'b100, 2'd2, 12'h000, 1'b0), "to_grant2");
    for (int n = 0; n < 3; n++)
      step(1'b1, 3'b101, 12'h5a5, 12'h000, 12'h3c3, mk_e(3'b100, 2'd2, 12'h3c3, 1'b0), "to_own2");
    step(1'b1, 3'b001, 12'h5a5, 12'h000, 12'h3c3, idle_e, "to_rel2");
    step(1'b1, 3'b001, 12'h5a5, 12'h000, 12'h3c3, mk_e(3'b001, 2'd0, 12'h000, 1'b0), "to_regrant0");

    // Release coinciding with timeout is a plain release.
    step(1'b0, 3'b000, 12'h123, 12'h000, 12'h456, idle_e, "rt_rst");
    step(1'b1, 3'b001, 12'h123, 12'h000, 12'h456, mk_e(3'b001, 2'd0, 12'h000, 1'b0), "rt_grant");
    for (int n = 2; n <= 16; n++)
      step(1'b1, 3'b101, 12'h123, 12'h000, 12'h456, mk_e(3'b001, 2'd0, 12'h123, 1'b0), "rt_own");
    step(1'b1, 3'b100, 12'h123, 12'h000, 12'h456, idle_e, "rt_release");
    step(1'b1, 3'b100, 12'h123, 12'h000, 12'h456, mk_e(3'b100, 2'd2, 12'h000, 1'b0), "rt_grant2");

    // No contender: ownership continues past the timeout with no revoke.
    step(1'b0, 3'b000, 12'h000, 12'h777, 12'h000, idle_e, "nc_rst");
    step(1'b1, 3'b010, 12'h000, 12'h777, 12'h000, mk_e(3'b010, 2'd1, 12'h000, 1'b0), "nc_grant");
    for (int n = 2; n <= 40; n++)
      step(1'b1, 3'b010, 12'h000, 12'h777, 12'h000, mk_e(3'b010, 2'd1, 12'h777, 1'b0), "nc_hold");
    step(1'b1, 3'b000, 12'h000, 12'h777, 12'h000, idle_e, "nc_rel");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/led_share_arb.md
Name: led_share_arb

Overview:
Arbiter that shares the 12-LED bank between three pattern sources (e.g. the fill/sweep pattern engine, a status display, an error flasher). Each source requests ownership with a level req/grant handshake. The arbiter picks an owner round-robin, enforces a minimum display hold time and a maximum ownership time, and registers the owner's pattern onto the LED pins. It sits between the pattern generators and the board LED outputs and runs on the 50 MHz system clock.

Parameters:
W, 12, LED bank width
HOLD_CYC, 25_000_000, minimum cycles an owner keeps the LEDs after grant (0.5 s at 50 MHz); must be >= 1
TIMEOUT_CYC, 250_000_000, ownership cycles after which a waiting requester forces revocation; must be > HOLD_CYC
IDLE_PAT, 12'h000, LED value shown when no owner

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  synchronous, active-low reset
req  in  3  level request per source; held high while the source wants the LEDs
data0  in  W  pattern from source 0
data1  in  W  pattern from source 1
data2  in  W  pattern from source 2
grant  out  3  one-hot ownership; all-zero when idle
owner  out  2  index of current owner; 2'd3 when idle
led  out  W  registered LED drive
revoked  out  1  one-cycle pulse when ownership ends by timeout

Behaviour:
- Reset (rst low at posedge clk): grant=0, owner=3, led=IDLE_PAT, revoked=0, cnt=0, last=2 (so source 0 wins the first contention), state=IDLE. Reset overrides everything mid-grant; no hold or timeout is honoured.
- All outputs are registered. The hold/timeout counter is 32 bits.
- State IDLE:
  - grant=0, owner=3, led=IDLE_PAT.
  - If any req bit is high, choose the first set bit searching last+1, last+2, last+3 (mod 3).
  - Next cycle: grant[i]=1, owner=i, last=i, cnt=0, state=OWN.
  - Latency from req rise (arbiter idle) to grant is 1 cycle.
- State OWN:
  - cnt increments every cycle and saturates at TIMEOUT_CYC.
  - led <= data[owner] only while req[owner]=1, so led reflects data with 1-cycle latency. Once req[owner] falls, led freezes at the last sampled value.
  - Normal release: req[owner]=0 and cnt >= HOLD_CYC-1. Next cycle grant=0, owner=3, led=IDLE_PAT, state=IDLE.
  - Early drop: if req[owner] falls before the hold expires, grant stays asserted and led stays frozen until cnt reaches HOLD_CYC-1. Release then follows on the next cycle.
  - Timeout: cnt >= TIMEOUT_CYC-1 and any other req bit high. Next cycle grant=0, owner=3, led=IDLE_PAT, revoked=1 for one cycle, state=IDLE.
  - Timeout with no other requester: ownership continues indefinitely and cnt stays saturated.
  - Re-raising req[owner] during the frozen-hold window resumes sampling; no re-grant is needed.
  - Release and timeout on the same cycle: treat as a normal release (revoked=0).
- Between any two owners there is at least one IDLE cycle with grant=0 and led=IDLE_PAT.
- After release or revoke, the pointer rotates: the previous owner has the lowest priority on the next arbitration. A revoked requester that still holds req is re-queued behind the others.
- Simultaneous requests in IDLE are resolved by the pointer only. Requests arriving during OWN wait; there is no preemption except by timeout.
- grant is never multi-hot. owner and grant are always consistent.

Test Plan:
(Bench uses HOLD_CYC=4, TIMEOUT_CYC=16.)
- Reset then single request: rst low 2 cycles, then req=001 with data0=12'h801 → grant=001 and owner=0 one cycle after req. led=12'h801 one cycle after grant. Drop req after 6 cycles → next cycle grant=000, led=12'h000.
- Simultaneous requests and round-robin: req=111 held, each requester drops req 5 cycles after its grant and raises it again 1 cycle later → grant order 001, 010, 100, 001, with exactly one all-zero grant cycle between owners.
- Early drop and freeze: source 1 granted, data1=12'hfff, req1 falls 1 cycle after grant while data1 changes to 12'h0f0 → led stays 12'hfff; grant=010 persists until cnt=3; grant=000 on the next cycle.
- Timeout revocation: source 0 holds req forever; req2 rises at cnt=5 → at cnt=15 grant=000 and revoked=1 for one cycle, then grant=100. Source 0 is regranted only after source 2 releases.
- Timeout with no contender: source 1 holds req for 40 cycles alone → grant=010 throughout, revoked never asserts.
- Reset mid-grant: source 2 owns with led=12'h3c3, rst low for 1 cycle → next cycle grant=000, owner=3, led=12'h000. After reset, req=101 → source 0 is granted first.
